// File: rtl/hms_clock_core.sv
// rtl/hms_clock_core.sv - HMS clock timekeeping core: 1 Hz tick, button debounce, mode/position FSM, h:m:s counters.
// Optional alarm (alarm_min/alarm_hour registers, o_alarm) is built only when HMS_ALARM_EN is defined.
module hms_clock_core #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int DEB_DIV  = 500_000,
   parameter int HOUR_MAX = 23
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw_mode,
   input  logic       i_sw_pos,
   input  logic       i_sw_inc,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_mode,
`ifdef HMS_ALARM_EN
   output logic [2:0] o_position,
`else
   output logic [1:0] o_position,
`endif
   output logic       o_tick,
   output logic       o_alarm
);

`ifdef HMS_ALARM_EN
   localparam int PW = 3;
   localparam logic [PW-1:0] P_AMIN  = PW'(3);
   localparam logic [PW-1:0] P_AHOUR = PW'(4);
`else
   localparam int PW = 2;
`endif
   localparam logic [PW-1:0] P_SEC  = PW'(0);
   localparam logic [PW-1:0] P_MIN  = PW'(1);
   localparam logic [PW-1:0] P_HOUR = PW'(2);

   localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

   typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   pos_nx;
   logic            do_inc;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [DW-1:0]   deb_cnt;
   logic            deb_strobe;
   logic [2:0]      sync1, sync2, samp, press;

   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   // hour at or beyond HOUR_MAX wraps, so an out-of-range value recovers
   function automatic logic [4:0] inc_hour(input logic [4:0] v);
      return (int'(v) >= HOUR_MAX) ? 5'd0 : v + 5'd1;
   endfunction

   // Button path: {mode, pos, inc}, idle high; history resets to released
   assign deb_strobe = (deb_cnt == DW'(DEB_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 3'b111;
         sync2   <= 3'b111;
         samp    <= 3'b111;
         press   <= 3'b000;
         deb_cnt <= '0;
      end else begin
         sync1   <= {i_sw_mode, i_sw_pos, i_sw_inc};
         sync2   <= sync1;
         deb_cnt <= deb_strobe ? '0 : deb_cnt + DW'(1);
         if (deb_strobe) begin
            press <= samp & ~sync2;
            samp  <= sync2;
         end else begin
            press <= 3'b000;
         end
      end
   end

   assign tick = (state == ST_CLOCK) && (tick_cnt == TW'(CLK_HZ - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         o_tick   <= 1'b0;
      end else begin
         o_tick <= tick;
         if (state != ST_CLOCK || tick)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLOCK;
         o_position <= P_SEC;
      end else begin
         state      <= state_nx;
         o_position <= pos_nx;
      end
   end

   // mode beats pos and inc; pos beats inc
   always_comb begin
      state_nx = state;
      pos_nx   = o_position;
      do_inc   = 1'b0;
      case (state)
         ST_CLOCK: begin
            if (press[2]) begin
               state_nx = ST_SETUP;
               pos_nx   = P_SEC;
            end
         end
         ST_SETUP: begin
            if (press[2]) begin
               state_nx = ST_CLOCK;
            end else if (press[1]) begin
               case (o_position)
                  P_SEC:   pos_nx = P_MIN;
                  P_MIN:   pos_nx = P_HOUR;
`ifdef HMS_ALARM_EN
                  P_HOUR:  pos_nx = P_AMIN;
                  P_AMIN:  pos_nx = P_AHOUR;
`endif
                  default: pos_nx = P_SEC;
               endcase
            end else if (press[0]) begin
               do_inc = 1'b1;
            end
         end
         default: state_nx = ST_CLOCK;
      endcase
   end

   assign o_mode = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_sec  <= 6'd0;
         o_min  <= 6'd0;
         o_hour <= 5'd0;
      end else if (tick) begin
         o_sec <= inc60(o_sec);
         if (o_sec >= 6'd59) begin
            o_min <= inc60(o_min);
            if (o_min >= 6'd59)
               o_hour <= inc_hour(o_hour);
         end
      end else if (do_inc) begin
         case (o_position)
            P_SEC:   o_sec  <= inc60(o_sec);
            P_MIN:   o_min  <= inc60(o_min);
            P_HOUR:  o_hour <= inc_hour(o_hour);
            default: ;
         endcase
      end
   end

`ifdef HMS_ALARM_EN
   logic [5:0] alarm_min, alarm_cnt;
   logic [4:0] alarm_hour;
   logic       alarm_match;

   assign alarm_match = (o_hour == alarm_hour) && (o_min == alarm_min) && (o_sec == 6'd0);

   // o_tick marks the cycle the fields have just advanced; 60 of them bound the alarm
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_min  <= 6'd0;
         alarm_hour <= 5'd0;
         alarm_cnt  <= 6'd0;
         o_alarm    <= 1'b0;
      end else begin
         if (do_inc && o_position == P_AMIN)
            alarm_min <= inc60(alarm_min);
         if (do_inc && o_position == P_AHOUR)
            alarm_hour <= inc_hour(alarm_hour);
         if (|press) begin
            o_alarm   <= 1'b0;
            alarm_cnt <= 6'd0;
         end else if (o_tick && state == ST_CLOCK) begin
            if (alarm_match) begin
               o_alarm   <= 1'b1;
               alarm_cnt <= 6'd0;
            end else if (o_alarm) begin
               if (alarm_cnt == 6'd59)
                  o_alarm <= 1'b0;
               else
                  alarm_cnt <= alarm_cnt + 6'd1;
            end
         end
      end
   end
`else
   assign o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_hms_clock_core.sv
// tb/tb_hms_clock_core.sv - directed bench for hms_clock_core (CLK_HZ=10, DEB_DIV=2); HOUR_MAX 23 and 11 instances.
// Alarm sequence is included when HMS_ALARM_EN is defined.
module tb_hms_clock_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_mode = 1'b1, sw_pos = 1'b1, sw_inc = 1'b1;
   logic [5:0] sec1, min1, sec2, min2;
   logic [4:0] hour1, hour2;
   logic       mode1, tick1, alarm1, mode2, tick2, alarm2;
`ifdef HMS_ALARM_EN
   logic [2:0] pos1, pos2;
`else
   logic [1:0] pos1, pos2;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ticks = 0;

   always #5 clk = ~clk;

   hms_clock_core #(.CLK_HZ(10), .DEB_DIV(2), .HOUR_MAX(23)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc),
      .o_sec(sec1), .o_min(min1), .o_hour(hour1), .o_mode(mode1), .o_position(pos1),
      .o_tick(tick1), .o_alarm(alarm1));

   hms_clock_core #(.CLK_HZ(10), .DEB_DIV(2), .HOUR_MAX(11)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc),
      .o_sec(sec2), .o_min(min2), .o_hour(hour2), .o_mode(mode2), .o_position(pos2),
      .o_tick(tick2), .o_alarm(alarm2));

   // cyc = number of clock edges since reset release; the debounce sampler fires on even cyc
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst_n)     ticks <= 0;
      else if (tick1) ticks <= ticks + 1;
   end

   typedef struct {
      logic m, p, i;
      int   mode, pos, sec, min, hour;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
   endtask

   task automatic press_hold(input logic m, input logic p, input logic i, input int hold);
      sw_mode = ~m;
      sw_pos  = ~p;
      sw_inc  = ~i;
      cycles(hold);
   endtask

   task automatic release_all();
      sw_mode = 1'b1;
      sw_pos  = 1'b1;
      sw_inc  = 1'b1;
      cycles(10);
   endtask

   task automatic press(input logic m, input logic p, input logic i);
      press_hold(m, p, i, 10);
      release_all();
   endtask

   vec_t tbl[8];
   int   n, found, t0, t1;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 1, 0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 2, 0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 3, 0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1, 2, 0, 3, 0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1, 2, 0, 3, 1};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 0, 2, 0, 3, 1};

      // reset state
      cycles(2);
      chk("rst_sec", sec1, 0);   chk("rst_min", min1, 0);  chk("rst_hour", hour1, 0);
      chk("rst_mode", mode1, 0); chk("rst_pos", pos1, 0);  chk("rst_tick", tick1, 0);
      chk("rst_alarm", alarm1, 0);

      // free run: field advances on edges 10, 20, ...
      rst_n = 1'b1;
      cycles(599);
      chk("run_sec59", sec1, 59);
      chk("run_ticks59", ticks, 59);
      chk("run_min0", min1, 0);
      cycles(10);
      chk("run_sec0", sec1, 0);
      chk("run_min1", min1, 1);
      chk("run_ticks60", ticks, 60);

      // setup-mode table, checked at the end of each 10-cycle hold
      do_reset();
      for (int k = 0; k < 8; k++) begin
         press_hold(tbl[k].m, tbl[k].p, tbl[k].i, 10);
         chk($sformatf("tbl%0d_mode", k), mode1, tbl[k].mode);
         chk($sformatf("tbl%0d_pos", k), pos1, tbl[k].pos);
         chk($sformatf("tbl%0d_sec", k), sec1, tbl[k].sec);
         chk($sformatf("tbl%0d_min", k), min1, tbl[k].min);
         chk($sformatf("tbl%0d_hour", k), hour1, tbl[k].hour);
         release_all();
      end

      // field wrap without carry
      press(1'b1, 1'b0, 1'b0);
      chk("setup_mode", mode1, 1);
      chk("setup_pos", pos1, 0);
      n = (58 - int'(sec1) + 60) % 60;
      repeat (n) press(1'b0, 1'b0, 1'b1);
      chk("sec58", sec1, 58);
      repeat (3) press(1'b0, 1'b0, 1'b1);
      chk("sec_wrap", sec1, 1);
      chk("sec_wrap_min", min1, 3);
      chk("sec_wrap_hour", hour1, 1);

      // long hold gives one increment; unsampled glitch gives none
      press_hold(1'b0, 1'b0, 1'b1, 200);
      release_all();
      chk("hold_once", sec1, 2);
      while (cyc % 2 != 0) cycles(1);
      sw_inc = 1'b0;
      cycles(1);
      sw_inc = 1'b1;
      cycles(20);
      chk("glitch", sec1, 2);

      // preload 23:59:59 (11:59:59 on the 12 h instance) and roll over
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      repeat (59) press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      repeat (59) press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      repeat (23) press(1'b0, 1'b0, 1'b1);
      chk("pre_sec", sec1, 59);  chk("pre_min", min1, 59);  chk("pre_hour", hour1, 23);
      chk("pre_hour12", hour2, 11);
      sw_mode = 1'b0;
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         cycles(1);
         if (!mode1) found = 1;
      end
      chk("exit_seen", found, 1);
      t0 = cyc;
      chk("exit_hold_sec", sec1, 59);
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         cycles(1);
         if (tick1) found = 1;
      end
      chk("exit_tick_seen", found, 1);
      t1 = cyc;
      chk("exit_tick_delay", t1 - t0, 10);
      chk("roll_sec", sec1, 0);  chk("roll_min", min1, 0);  chk("roll_hour", hour1, 0);
      chk("roll12_sec", sec2, 0); chk("roll12_min", min2, 0); chk("roll12_hour", hour2, 0);
      sw_mode = 1'b1;

      // asynchronous reset during setup with a press in flight
      cycles(25);
      press(1'b1, 1'b0, 1'b0);
      sw_pos = 1'b0;
      cycles(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sec", sec1, 0);   chk("arst_mode", mode1, 0); chk("arst_pos", pos1, 0);
      chk("arst_tick", tick1, 0); chk("arst_min", min1, 0);   chk("arst_hour", hour1, 0);
      chk("arst_mode2", mode2, 0);
      cycles(2);
      sw_pos = 1'b1;
      cycles(1);
      rst_n = 1'b1;
      cycles(50);
      chk("post_mode", mode1, 0);
      chk("post_pos", pos1, 0);
      chk("post_sec", sec1, 5);

`ifdef HMS_ALARM_EN
      do_reset();
      press(1'b1, 1'b0, 1'b0);
      repeat (3) press(1'b0, 1'b1, 1'b0);
      chk("al_pos3", pos1, 3);
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      chk("al_pos4", pos1, 4);
      press(1'b0, 1'b1, 1'b0);
      chk("al_pos0", pos1, 0);
      press(1'b1, 1'b0, 1'b0);
      found = 0;
      for (int k = 0; k < 800 && found == 0; k++) begin
         if (alarm1) found = 1;
         else cycles(1);
      end
      chk("al_rise", found, 1);
      chk("al_rise_min", min1, 1);
      chk("al_rise_sec", sec1, 0);
      n = 0;
      while (alarm1 && n < 700) begin
         n++;
         cycles(1);
      end
      chk("al_len", n, 600);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
